// File: rtl/gin_pkg.sv
// rtl/gin_pkg.sv - shared constants and index helpers for the GIN multicast network
// Contents:
//   GIN_MAX_ID_W  widest supported ID/tag width
//   GIN_WILDCARD  all-ones tag; slice the low ID_W bits for the instance width
//   pe_idx        flat index of PE(r,c), which is also its column-ID register
//   row_id_idx    flat index of the row-ID register for row r
package gin_pkg;

    localparam int GIN_MAX_ID_W = 64;
    localparam logic [GIN_MAX_ID_W-1:0] GIN_WILDCARD = '1;

    function automatic int pe_idx(input int r, input int c, input int num_cols);
        return r * num_cols + c;
    endfunction

    // Row IDs sit above the R*C column-ID registers.
    function automatic int row_id_idx(input int r, input int num_rows, input int num_cols);
        return num_rows * num_cols + r;
    endfunction

endpackage

// File: rtl/gin_id_scan_chain.sv
// rtl/gin_id_scan_chain.sv - serial-load shift register holding the GIN row/column IDs
// Ports:
//   clk, nrst      clock, synchronous active-low reset
//   scan_en        shift one position this cycle
//   scan_in        value entering the top register (index N-1)
//   ids            all N registers, register i at bits [i*ID_W +: ID_W]
//   scan_out       contents of register 0
module gin_id_scan_chain #(
    parameter int N    = 12,
    parameter int ID_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              scan_en,
    input  logic [ID_W-1:0]   scan_in,
    output logic [N*ID_W-1:0] ids,
    output logic [ID_W-1:0]   scan_out
);

    logic [N*ID_W-1:0] regs;

    // Values enter at the top and move toward index 0, so the first value
    // shifted in reaches register 0 after N shifts.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            regs <= '0;
        end else if (scan_en) begin
            regs <= {scan_in, regs[N*ID_W-1:ID_W]};
        end
    end

    assign ids      = regs;
    assign scan_out = regs[ID_W-1:0];

endmodule

// File: rtl/gin_multicast_network.sv
// rtl/gin_multicast_network.sv - GIN multicast fabric with tag matching, backpressure and drop counter
// Ports:
//   clk, nrst                        clock, synchronous active-low reset
//   enable_i                         allows new packets to be accepted
//   id_scan_en_i/id_scan_i/id_scan_o ID scan chain control, serial in, serial out
//   in_valid_i/in_ready_o            input handshake
//   in_data_i, in_tag_row_i/col_i    payload and destination tags
//   pe_valid_o/pe_ready_i            per-PE handshake, PE(r,c) at bit r*C+c
//   pe_data_o                        held payload, broadcast to all PEs
//   busy_o                           a packet is still pending delivery
//   drop_cnt_o                       saturating count of accepted packets with no target
module gin_multicast_network
    import gin_pkg::*;
#(
    parameter int NUM_ROWS   = 3,
    parameter int NUM_COLS   = 3,
    parameter int DATA_W     = 8,
    parameter int ID_W       = 8,
    parameter int DROP_CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         enable_i,
    input  logic                         id_scan_en_i,
    input  logic [ID_W-1:0]              id_scan_i,
    output logic [ID_W-1:0]              id_scan_o,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_W-1:0]            in_data_i,
    input  logic [ID_W-1:0]              in_tag_row_i,
    input  logic [ID_W-1:0]              in_tag_col_i,
    output logic [NUM_ROWS*NUM_COLS-1:0] pe_valid_o,
    output logic [DATA_W-1:0]            pe_data_o,
    input  logic [NUM_ROWS*NUM_COLS-1:0] pe_ready_i,
    output logic                         busy_o,
    output logic [DROP_CNT_W-1:0]        drop_cnt_o
);

    localparam int NUM_PE  = NUM_ROWS * NUM_COLS;
    localparam int NUM_IDS = NUM_PE + NUM_ROWS;
    localparam logic [ID_W-1:0] WILDCARD = GIN_WILDCARD[ID_W-1:0];

    logic [NUM_IDS*ID_W-1:0] ids;
    logic [NUM_PE-1:0]       pending;
    logic [NUM_PE-1:0]       pending_keep;
    logic [NUM_PE-1:0]       match_mask;
    logic [DATA_W-1:0]       data_q;
    logic [DROP_CNT_W-1:0]   drop_cnt;
    logic                    accept;

    gin_id_scan_chain #(
        .N    (NUM_IDS),
        .ID_W (ID_W)
    ) u_id_scan_chain (
        .clk      (clk),
        .nrst     (nrst),
        .scan_en  (id_scan_en_i),
        .scan_in  (id_scan_i),
        .ids      (ids),
        .scan_out (id_scan_o)
    );

    // Match against the IDs as they stand this cycle; the result is frozen
    // into pending, so later scans cannot retarget an in-flight packet.
    always_comb begin
        match_mask = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                match_mask[pe_idx(r, c, NUM_COLS)] =
                    ((in_tag_row_i == ids[row_id_idx(r, NUM_ROWS, NUM_COLS)*ID_W +: ID_W]) ||
                     (in_tag_row_i == WILDCARD)) &&
                    ((in_tag_col_i == ids[pe_idx(r, c, NUM_COLS)*ID_W +: ID_W]) ||
                     (in_tag_col_i == WILDCARD));
            end
        end
    end

    // Bits still owed after this cycle's handshakes; a new packet may enter
    // only when nothing would remain, which lets release and accept overlap.
    assign pending_keep = pending & ~pe_ready_i;
    assign in_ready_o   = nrst & enable_i & ~id_scan_en_i & (pending_keep == '0);
    assign accept       = in_valid_i & in_ready_o;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pending  <= '0;
            data_q   <= '0;
            drop_cnt <= '0;
        end else begin
            pending <= pending_keep;
            if (accept) begin
                if (match_mask != '0) begin
                    pending <= match_mask;
                    data_q  <= in_data_i;
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    assign pe_valid_o = pending;
    assign pe_data_o  = data_q;
    assign busy_o     = |pending;
    assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_gin_multicast_network.sv
// tb/tb_gin_multicast_network.sv - self-checking bench for gin_multicast_network
module tb_gin_multicast_network;

    logic       clk;
    logic       nrst;
    logic       enable_i;
    logic       id_scan_en_i;
    logic [7:0] id_scan_i;
    logic [7:0] id_scan_o;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_data_i;
    logic [7:0] in_tag_row_i;
    logic [7:0] in_tag_col_i;
    logic [8:0] pe_valid_o;
    logic [7:0] pe_data_o;
    logic [8:0] pe_ready_i;
    logic       busy_o;
    logic [7:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    gin_multicast_network #(
        .NUM_ROWS   (3),
        .NUM_COLS   (3),
        .DATA_W     (8),
        .ID_W       (8),
        .DROP_CNT_W (8)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .enable_i     (enable_i),
        .id_scan_en_i (id_scan_en_i),
        .id_scan_i    (id_scan_i),
        .id_scan_o    (id_scan_o),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .in_tag_row_i (in_tag_row_i),
        .in_tag_col_i (in_tag_col_i),
        .pe_valid_o   (pe_valid_o),
        .pe_data_o    (pe_data_o),
        .pe_ready_i   (pe_ready_i),
        .busy_o       (busy_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       vld;
        logic [7:0] data;
        logic [7:0] trow;
        logic [7:0] tcol;
        logic [8:0] rdy;
        logic       exp_rdy;
        logic [8:0] exp_valid;
        logic [7:0] exp_data;
        logic       exp_busy;
        logic [7:0] exp_drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic vld, input logic [7:0] data,
                                input logic [7:0] trow, input logic [7:0] tcol,
                                input logic [8:0] rdy, input logic exp_rdy,
                                input logic [8:0] exp_valid, input logic [7:0] exp_data,
                                input logic exp_busy, input logic [7:0] exp_drop);
        vec_t v;
        v.en = en; v.vld = vld; v.data = data; v.trow = trow; v.tcol = tcol; v.rdy = rdy;
        v.exp_rdy = exp_rdy; v.exp_valid = exp_valid; v.exp_data = exp_data;
        v.exp_busy = exp_busy; v.exp_drop = exp_drop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Shift the 3x3 ID image: column IDs are c, row IDs are r, reg0 first.
    task automatic load_ids();
        for (int i = 0; i < 12; i++) begin
            id_scan_en_i = 1'b1;
            id_scan_i    = 8'(i % 3);
            @(posedge clk); #1;
        end
        id_scan_en_i = 1'b0;
        id_scan_i    = 8'h00;
    endtask

    // Drive one table row, check ready before the edge and state after it.
    task automatic apply(input vec_t v, input int idx);
        enable_i     = v.en;
        in_valid_i   = v.vld;
        in_data_i    = v.data;
        in_tag_row_i = v.trow;
        in_tag_col_i = v.tcol;
        pe_ready_i   = v.rdy;
        #1;
        chk($sformatf("vec%0d in_ready", idx), 32'(in_ready_o), 32'(v.exp_rdy));
        @(posedge clk); #1;
        chk($sformatf("vec%0d pe_valid", idx), 32'(pe_valid_o), 32'(v.exp_valid));
        chk($sformatf("vec%0d pe_data", idx), 32'(pe_data_o), 32'(v.exp_data));
        chk($sformatf("vec%0d busy", idx), 32'(busy_o), 32'(v.exp_busy));
        chk($sformatf("vec%0d drop_cnt", idx), 32'(drop_cnt_o), 32'(v.exp_drop));
    endtask

    initial begin
        nrst = 1'b0; enable_i = 1'b0; id_scan_en_i = 1'b0; id_scan_i = 8'h00;
        in_valid_i = 1'b0; in_data_i = 8'h00; in_tag_row_i = 8'h00; in_tag_col_i = 8'h00;
        pe_ready_i = 9'h000;

        // Unicast, multicast with stall, drop, full wildcard, partial drain, enable low.
        tbl.push_back(mk(1, 1, 8'h11, 8'd1,  8'd2,  9'h1FF, 1, 9'h020, 8'h11, 1, 8'd0));
        tbl.push_back(mk(1, 1, 8'h22, 8'd1,  8'd2,  9'h1FF, 1, 9'h020, 8'h22, 1, 8'd0));
        tbl.push_back(mk(1, 0, 8'h00, 8'd0,  8'd0,  9'h1FF, 1, 9'h000, 8'h22, 0, 8'd0));
        tbl.push_back(mk(1, 1, 8'hA5, 8'hFF, 8'd0,  9'h1FF, 1, 9'h049, 8'hA5, 1, 8'd0));
        tbl.push_back(mk(1, 1, 8'h5A, 8'd1,  8'd2,  9'h1F7, 0, 9'h008, 8'hA5, 1, 8'd0));
        tbl.push_back(mk(1, 1, 8'h5A, 8'd1,  8'd2,  9'h1F7, 0, 9'h008, 8'hA5, 1, 8'd0));
        tbl.push_back(mk(1, 1, 8'h5A, 8'd1,  8'd2,  9'h1FF, 1, 9'h020, 8'h5A, 1, 8'd0));
        tbl.push_back(mk(1, 0, 8'h00, 8'd0,  8'd0,  9'h1FF, 1, 9'h000, 8'h5A, 0, 8'd0));
        tbl.push_back(mk(1, 1, 8'h77, 8'd7,  8'd0,  9'h1FF, 1, 9'h000, 8'h5A, 0, 8'd1));
        tbl.push_back(mk(1, 1, 8'h3C, 8'hFF, 8'hFF, 9'h000, 1, 9'h1FF, 8'h3C, 1, 8'd1));
        tbl.push_back(mk(1, 1, 8'h44, 8'd0,  8'd1,  9'h0F0, 0, 9'h10F, 8'h3C, 1, 8'd1));
        tbl.push_back(mk(1, 1, 8'h44, 8'd0,  8'd1,  9'h10F, 1, 9'h002, 8'h44, 1, 8'd1));
        tbl.push_back(mk(0, 1, 8'h99, 8'd2,  8'd2,  9'h000, 0, 9'h002, 8'h44, 1, 8'd1));
        tbl.push_back(mk(0, 1, 8'h99, 8'd2,  8'd2,  9'h1FF, 0, 9'h000, 8'h44, 0, 8'd1));
        tbl.push_back(mk(1, 1, 8'h81, 8'd2,  8'd2,  9'h000, 1, 9'h100, 8'h81, 1, 8'd1));
        tbl.push_back(mk(0, 1, 8'h82, 8'd2,  8'd2,  9'h0FF, 0, 9'h100, 8'h81, 1, 8'd1));
        tbl.push_back(mk(0, 1, 8'h82, 8'd2,  8'd2,  9'h1FF, 0, 9'h000, 8'h81, 0, 8'd1));

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("reset pe_valid", 32'(pe_valid_o), 32'h0);
        chk("reset pe_data", 32'(pe_data_o), 32'h0);
        chk("reset busy", 32'(busy_o), 32'h0);
        chk("reset in_ready", 32'(in_ready_o), 32'h0);
        chk("reset drop_cnt", 32'(drop_cnt_o), 32'h0);
        chk("reset id_scan_o", 32'(id_scan_o), 32'h0);
        nrst = 1'b1;

        load_ids();
        chk("scan load id_scan_o", 32'(id_scan_o), 32'h0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Drop counter saturation: one drop so far, 300 more must stop at 255.
        enable_i = 1'b1; in_valid_i = 1'b1; in_tag_row_i = 8'd7; in_tag_col_i = 8'd0;
        pe_ready_i = 9'h1FF;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
        end
        chk("drop saturate", 32'(drop_cnt_o), 32'd255);
        chk("drop pe_valid", 32'(pe_valid_o), 32'h0);
        chk("drop pe_data kept", 32'(pe_data_o), 32'h81);

        // Mid-delivery reset with all nine PEs pending.
        in_tag_row_i = 8'hFF; in_tag_col_i = 8'hFF; in_data_i = 8'hE7; pe_ready_i = 9'h000;
        @(posedge clk); #1;
        chk("pre-reset pe_valid", 32'(pe_valid_o), 32'h1FF);
        in_valid_i = 1'b0;
        nrst = 1'b0;
        @(posedge clk); #1;
        chk("mid reset pe_valid", 32'(pe_valid_o), 32'h0);
        chk("mid reset drop_cnt", 32'(drop_cnt_o), 32'h0);
        chk("mid reset id_scan_o", 32'(id_scan_o), 32'h0);
        chk("mid reset busy", 32'(busy_o), 32'h0);
        chk("mid reset in_ready", 32'(in_ready_o), 32'h0);
        nrst = 1'b1;
        #1;
        chk("post reset in_ready", 32'(in_ready_o), 32'h1);

        // Shift-out: reload, then shifting zeros walks 1,2,0,... out of reg0,
        // and every shifting cycle refuses a valid packet.
        load_ids();
        in_valid_i = 1'b1; in_tag_row_i = 8'hFF; in_tag_col_i = 8'hFF; pe_ready_i = 9'h1FF;
        for (int k = 0; k < 11; k++) begin
            id_scan_en_i = 1'b1;
            id_scan_i    = 8'h00;
            #1;
            chk($sformatf("scan%0d in_ready", k), 32'(in_ready_o), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("scan%0d id_scan_o", k), 32'(id_scan_o), 32'((k + 1) % 3));
            chk($sformatf("scan%0d pe_valid", k), 32'(pe_valid_o), 32'h0);
        end
        id_scan_en_i = 1'b0;
        in_valid_i   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
